// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential integer ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: op-code enum, FSM state enum, is_muldiv() helper and LUI_SHIFT.
// Optional feature macro: ALU_MULDIV_EN adds the CALC state.
`timescale 1ns/1ps
package alu_pkg;

    localparam int LUI_SHIFT = 12;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00,
        ALU_SLT    = 5'h01,
        ALU_SLTU   = 5'h02,
        ALU_AND    = 5'h03,
        ALU_OR     = 5'h04,
        ALU_XOR    = 5'h05,
        ALU_LUI    = 5'h06,
        ALU_SLL    = 5'h07,
        ALU_SRL    = 5'h08,
        ALU_SUB    = 5'h09,
        ALU_SRA    = 5'h0A,
        ALU_MUL    = 5'h10,
        ALU_MULH   = 5'h11,
        ALU_MULHSU = 5'h12,
        ALU_MULHU  = 5'h13,
        ALU_DIV    = 5'h14,
        ALU_DIVU   = 5'h15,
        ALU_REM    = 5'h16,
        ALU_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
        CALC = 2'd2,
`endif
        DONE = 2'd1
    } alu_state_e;

    // Op codes 10..17 form the multiply/divide group.
    function automatic logic is_muldiv(input alu_op_e op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M engine: radix-2 shift-add multiply and restoring divide on magnitudes.
// Latency: XLEN cycles after i_start; o_done/o_result valid combinationally in the last one.
// Backpressure: none; the caller holds the result, start is only issued from idle.
// Ports: clk, reset (sync, active-high), i_start/i_op/i_a/i_b operands,
//        o_done final-iteration strobe, o_result sign-corrected result for that cycle.
`timescale 1ns/1ps
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  alu_op_e         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic [CNT_W-1:0]  r_cnt;
    // {hi, lo}: multiply = {partial sum, remaining multiplier bits},
    //           divide   = {partial remainder, dividend/quotient bits}.
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;    // multiplicand or divisor magnitude
    alu_op_e           r_op;
    logic              r_qneg;   // product / quotient must be negated
    logic              r_rneg;   // remainder must be negated

    logic              w_a_sgn, w_b_sgn;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN-1:0]   w_hi, w_lo;
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem;

    // Which operands are treated as signed depends on the op.
    always_comb begin
        w_a_sgn = i_a[XLEN-1] & (i_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        w_b_sgn = i_b[XLEN-1] & (i_op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM});
        w_a_mag = w_a_sgn ? -i_a : i_a;
        w_b_mag = w_b_sgn ? -i_b : i_b;
    end

    assign w_hi = r_acc[2*XLEN-1:XLEN];
    assign w_lo = r_acc[XLEN-1:0];

    // Multiply step: add multiplicand if the current multiplier LSB is set, shift right.
    assign w_sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_sum, w_lo[XLEN-1:1]};

    // Divide step: shift in the next dividend bit, trial subtract, keep if no borrow.
    assign w_shift   = {w_hi, w_lo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_opb};
    assign w_div_nxt = w_diff[XLEN] ? {w_shift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],  w_lo[XLEN-2:0], 1'b1};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

    // Sign fix-up is applied to the value produced by the final iteration.
    assign w_prod = r_qneg ? -w_mul_nxt : w_mul_nxt;
    assign w_quo  = r_qneg ? -w_div_nxt[XLEN-1:0] : w_div_nxt[XLEN-1:0];
    assign w_rem  = r_rneg ? -w_div_nxt[2*XLEN-1:XLEN] : w_div_nxt[2*XLEN-1:XLEN];

    always_comb begin
        o_result = '0;
        case (r_op)
            ALU_MUL:                          o_result = w_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                o_result = w_quo;
            ALU_REM, ALU_REMU:                o_result = w_rem;
            default:                          o_result = '0;
        endcase
    end

    assign o_done = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opb  <= '0;
            r_op   <= ALU_ADD;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= CNT_W'(XLEN);
            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
            r_opb  <= w_b_mag;
            r_op   <= i_op;
            r_qneg <= w_a_sgn ^ w_b_sgn;
            r_rneg <= w_a_sgn;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_acc  <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential integer ALU: single-cycle RV32I ops, iterative RV32M ops when ALU_MULDIV_EN is defined.
// Latency: 1 cycle for RV32I, special-case div and illegal ops; XLEN+1 cycles for mul/div.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (issue every >= 2 cycles).
// Ports: clk, reset (sync, active-high); in_valid/in_ready with A, B, ALU_control;
//        out_valid/out_ready with registered result, zero_flag, illegal_op.
`timescale 1ns/1ps
module alu_seq import alu_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ALU_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            illegal_op
);

    alu_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] r_result;
    logic            r_zero, r_ill;

    alu_op_e         w_op;
    logic [CNT_W-2:0] w_shamt;   // shift amount is one bit narrower than the counter
    logic [XLEN-1:0] w_res;
    logic            w_ill;

    assign w_op    = alu_op_e'(ALU_control);
    assign w_shamt = B[CNT_W-2:0];

`ifdef ALU_MULDIV_EN
    logic            w_long, w_start, w_md_done, w_ovf;
    logic [XLEN-1:0] w_md_res;

    assign w_ovf = (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

    alu_muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_op     (w_op),
        .i_a      (A),
        .i_b      (B),
        .o_done   (w_md_done),
        .o_result (w_md_res)
    );
`endif

    // Single-cycle datapath, evaluated on the live inputs at acceptance.
    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
`ifdef ALU_MULDIV_EN
        w_long = 1'b0;
`endif
        case (w_op)
            ALU_ADD:  w_res = A + B;
            ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, (A < B)};
            ALU_AND:  w_res = A & B;
            ALU_OR:   w_res = A | B;
            ALU_XOR:  w_res = A ^ B;
            ALU_LUI:  w_res = B << LUI_SHIFT;
            ALU_SLL:  w_res = A << w_shamt;
            ALU_SRL:  w_res = A >> w_shamt;
            ALU_SUB:  w_res = A - B;
            ALU_SRA:  w_res = $signed(A) >>> w_shamt;
            default: begin
`ifdef ALU_MULDIV_EN
                if (is_muldiv(w_op)) begin
                    w_long = 1'b1;
                    // Divide-by-zero and signed overflow resolve without iterating.
                    if (w_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
                        if (B == '0) begin
                            w_long = 1'b0;
                            w_res  = (w_op inside {ALU_DIV, ALU_DIVU}) ? '1 : A;
                        end else if (w_ovf && (w_op inside {ALU_DIV, ALU_REM})) begin
                            w_long = 1'b0;
                            w_res  = (w_op == ALU_DIV) ? A : '0;
                        end
                    end
                end else begin
                    w_ill = 1'b1;
                end
`else
                w_ill = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
`ifdef ALU_MULDIV_EN
        w_start     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (w_long) begin
                        w_state_nxt = CALC;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            CALC: if (w_md_done) w_state_nxt = DONE;
`endif
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ill    <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            // Long ops load an interim value here; it is replaced before out_valid rises.
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_ill    <= w_ill;
`ifdef ALU_MULDIV_EN
        end else if (r_state == CALC && w_md_done) begin
            r_result <= w_md_res;
            r_zero   <= (w_md_res == '0);
            r_ill    <= 1'b0;
`endif
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign result     = r_result;
    assign zero_flag  = r_zero;
    assign illegal_op = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  ALU_control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero_flag;
    logic        illegal_op;

    int vec_cnt = 0;
    int miscmp  = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    exp_t exp_q[$];

    alu_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero_flag   (zero_flag),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input logic ill, input int lat);
        exp_t e;
        e.res = r;
        e.z   = (r == 32'h0);
        e.ill = ill;
        e.lat = 8'(lat);
        return e;
    endfunction

    // Mul/div expectation: executes when compiled in, otherwise an illegal 1-cycle op.
    function automatic exp_t mkmd(input logic [31:0] r, input int lat);
        return MD ? mk(r, 1'b0, lat) : mk(32'h0, 1'b1, 1);
    endfunction

    // Behavioural reference built on native 64-bit arithmetic.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0]        pu;
        logic [31:0]        r;
        logic               ill;
        int                 lat;
        r = '0; ill = 1'b0; lat = 1; p = '0; pu = '0;
        case (op)
            5'h00: r = a + b;
            5'h01: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h02: r = (a < b) ? 32'd1 : 32'd0;
            5'h03: r = a & b;
            5'h04: r = a | b;
            5'h05: r = a ^ b;
            5'h06: r = b << 12;
            5'h07: r = a << b[4:0];
            5'h08: r = a >> b[4:0];
            5'h09: r = a - b;
            5'h0A: r = $signed(a) >>> b[4:0];
`ifdef ALU_MULDIV_EN
            5'h10: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[31:0];  lat = 33; end
            5'h11: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; lat = 33; end
            5'h12: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});       r = p[63:32]; lat = 33; end
            5'h13: begin pu = {32'h0, a} * {32'h0, b};                              r = pu[63:32]; lat = 33; end
            5'h14: if (b == 0) r = '1;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                   else begin r = $signed(a) / $signed(b); lat = 33; end
            5'h15: if (b == 0) r = '1; else begin r = a / b; lat = 33; end
            5'h16: if (b == 0) r = a;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                   else begin r = $signed(a) % $signed(b); lat = 33; end
            5'h17: if (b == 0) r = a; else begin r = a % b; lat = 33; end
`endif
            default: ill = 1'b1;
        endcase
        return mk(r, ill, lat);
    endfunction

    // Drive one op into IDLE and record its expectation; operands scrambled afterwards.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ALU_control = op; A = a; B = b; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALU_control = 5'($urandom);
    endtask

    // Cycles from the accepting edge to the first out_valid (bounded).
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscmp++; $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        vec_cnt++;
        if ({result, zero_flag, illegal_op} !== {32'h0, 1'b1, 1'b0}) begin
            miscmp++; $display("FAIL reset_out: got %h z=%b ill=%b want 0 z=1 ill=0", result, zero_flag, illegal_op);
        end
        // out_ready with nothing pending must do nothing
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscmp++; $display("FAIL idle_out_ready: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        exp_t e;
        int   lat;
        send(5'h00, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 1'b0, 1));
        wait_out(lat);
        e = exp_q.pop_front();
        vec_cnt++;
        if (lat !== int'(e.lat)) begin
            miscmp++; $display("FAIL add_latency: got %0d want %0d", lat, e.lat);
        end
        vec_cnt++;
        if ({result, zero_flag, illegal_op} !== {e.res, e.z, e.ill}) begin
            miscmp++; $display("FAIL add_result: got %h z=%b ill=%b want %h z=%b ill=%b", result, zero_flag, illegal_op, e.res, e.z, e.ill);
        end
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            miscmp++; $display("FAIL add_in_ready_busy: got %b want 0", in_ready);
        end
        release_out();
    endtask

    task automatic test_sub_stall();
        exp_t e;
        int   lat;
        send(5'h09, 32'd5, 32'd5, mk(32'h0, 1'b0, 1));
        wait_out(lat);
        e = exp_q.pop_front();
        vec_cnt++;
        if (lat !== int'(e.lat) || {result, zero_flag, illegal_op} !== {e.res, e.z, e.ill}) begin
            miscmp++; $display("FAIL sub_result: got lat=%0d %h z=%b want lat=%0d %h z=%b", lat, result, zero_flag, e.lat, e.res, e.z);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({out_valid, in_ready, result, zero_flag, illegal_op} !== {1'b1, 1'b0, e.res, e.z, e.ill}) begin
                miscmp++; $display("FAIL sub_hold%0d: got v=%b rdy=%b %h z=%b want v=1 rdy=0 %h z=%b", i, out_valid, in_ready, result, zero_flag, e.res, e.z);
            end
        end
        release_out();
        @(negedge clk);
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscmp++; $display("FAIL sub_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [4:0]  ops [16];
        logic [31:0] as  [16];
        logic [31:0] bs  [16];
        exp_t        es  [16];
        exp_t        e;
        int          lat;
        ops[0]  = 5'h11; as[0]  = 32'hFFFF_FFFE; bs[0]  = 32'd3;         es[0]  = mkmd(32'hFFFF_FFFF, 33);
        ops[1]  = 5'h10; as[1]  = 32'hFFFF_FFFE; bs[1]  = 32'd3;         es[1]  = mkmd(32'hFFFF_FFFA, 33);
        ops[2]  = 5'h14; as[2]  = 32'hFFFF_FFF9; bs[2]  = 32'd2;         es[2]  = mkmd(32'hFFFF_FFFD, 33);
        ops[3]  = 5'h16; as[3]  = 32'hFFFF_FFF9; bs[3]  = 32'd2;         es[3]  = mkmd(32'hFFFF_FFFF, 33);
        ops[4]  = 5'h15; as[4]  = 32'd9;         bs[4]  = 32'd0;         es[4]  = mkmd(32'hFFFF_FFFF, 1);
        ops[5]  = 5'h16; as[5]  = 32'd9;         bs[5]  = 32'd0;         es[5]  = mkmd(32'd9, 1);
        ops[6]  = 5'h14; as[6]  = 32'h8000_0000; bs[6]  = 32'hFFFF_FFFF; es[6]  = mkmd(32'h8000_0000, 1);
        ops[7]  = 5'h16; as[7]  = 32'h8000_0000; bs[7]  = 32'hFFFF_FFFF; es[7]  = mkmd(32'h0, 1);
        ops[8]  = 5'h13; as[8]  = 32'hFFFF_FFFF; bs[8]  = 32'hFFFF_FFFF; es[8]  = mkmd(32'hFFFF_FFFE, 33);
        ops[9]  = 5'h1F; as[9]  = 32'd1;         bs[9]  = 32'd2;         es[9]  = mk(32'h0, 1'b1, 1);
        ops[10] = 5'h0B; as[10] = 32'd1;         bs[10] = 32'd2;         es[10] = mk(32'h0, 1'b1, 1);
        ops[11] = 5'h06; as[11] = 32'hDEAD_BEEF; bs[11] = 32'h0001_2345; es[11] = mk(32'h1234_5000, 1'b0, 1);
        ops[12] = 5'h0A; as[12] = 32'h8000_0000; bs[12] = 32'h0000_0024; es[12] = mk(32'hF800_0000, 1'b0, 1);
        ops[13] = 5'h01; as[13] = 32'hFFFF_FFFF; bs[13] = 32'd1;         es[13] = mk(32'd1, 1'b0, 1);
        ops[14] = 5'h02; as[14] = 32'hFFFF_FFFF; bs[14] = 32'd1;         es[14] = mk(32'd0, 1'b0, 1);
        ops[15] = 5'h15; as[15] = 32'd100;       bs[15] = 32'd7;         es[15] = mkmd(32'd14, 33);
        for (int i = 0; i < 16; i++) begin
            send(ops[i], as[i], bs[i], es[i]);
            wait_out(lat);
            e = exp_q.pop_front();
            vec_cnt++;
            if (lat !== int'(e.lat)) begin
                miscmp++; $display("FAIL dir%0d_op%h_latency: got %0d want %0d", i, ops[i], lat, e.lat);
            end
            vec_cnt++;
            if ({result, zero_flag, illegal_op} !== {e.res, e.z, e.ill}) begin
                miscmp++; $display("FAIL dir%0d_op%h_result: got %h z=%b ill=%b want %h z=%b ill=%b", i, ops[i], result, zero_flag, illegal_op, e.res, e.z, e.ill);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        exp_t        e;
        int          lat;
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = (i % 5 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            send(op, a, b, model(op, a, b));
            wait_out(lat);
            e = exp_q.pop_front();
            vec_cnt++;
            if (lat !== int'(e.lat) || {result, zero_flag, illegal_op} !== {e.res, e.z, e.ill}) begin
                miscmp++; $display("FAIL rnd%0d_op%h a=%h b=%h: got lat=%0d %h z=%b ill=%b want lat=%0d %h z=%b ill=%b",
                                   i, op, a, b, lat, result, zero_flag, illegal_op, e.lat, e.res, e.z, e.ill);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        @(negedge clk);
        A = 32'd3; B = 32'd4; ALU_control = 5'h00; in_valid = 1'b1;
        exp_q.push_back(mk(32'd7, 1'b0, 1));
        @(posedge clk);
        #1;
        // Second op stays valid while the block is busy; it must wait for IDLE.
        A = 32'd6; B = 32'd3; ALU_control = 5'h05;
        exp_q.push_back(mk(32'd5, 1'b0, 1));
        wait_out(lat);
        e = exp_q.pop_front();
        vec_cnt++;
        if (lat !== int'(e.lat) || result !== e.res || in_ready !== 1'b0) begin
            miscmp++; $display("FAIL b2b_first: got lat=%0d %h rdy=%b want lat=%0d %h rdy=0", lat, result, in_ready, e.lat, e.res);
        end
        release_out();
        @(negedge clk);
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscmp++; $display("FAIL b2b_idle: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        e = exp_q.pop_front();
        vec_cnt++;
        if (lat !== int'(e.lat) || {result, zero_flag, illegal_op} !== {e.res, e.z, e.ill}) begin
            miscmp++; $display("FAIL b2b_second: got lat=%0d %h want lat=%0d %h", lat, result, e.lat, e.res);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen;
        if (MD) begin
            send(5'h15, 32'd1000, 32'd7, model(5'h15, 32'd1000, 32'd7));
            repeat (10) @(negedge clk);
        end else begin
            send(5'h00, 32'd1, 32'd2, model(5'h00, 32'd1, 32'd2));
            @(negedge clk);
        end
        e = exp_q.pop_front();   // this op is discarded by the reset
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({in_ready, out_valid, result, zero_flag, illegal_op} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            miscmp++; $display("FAIL midreset_state: got rdy=%b v=%b %h z=%b ill=%b want 1 0 0 1 0", in_ready, out_valid, result, zero_flag, illegal_op);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vec_cnt++;
        if (seen !== 1'b0) begin
            miscmp++; $display("FAIL midreset_no_output: got out_valid seen=%b want 0", seen);
        end
        vec_cnt++;
        if (exp_q.size() !== 0) begin
            miscmp++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_stall();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle integer ALU in the execute stage. Executes the RV32I arithmetic/logic/shift/compare ops in one registered cycle. Adds iterative RV32M multiply/divide over a `XLEN`-cycle datapath. A valid/ready handshake on both sides lets the pipeline stall on long ops.

## Interface
Parameters:
- `XLEN`, 32: operand/result width, at least 8, power of two.
- `CNT_W`, `$clog2(XLEN)+1`: iteration counter width.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: operands and op present.
- `in_ready`, out, 1: block can accept; equals state==IDLE.
- `A`, in, XLEN: operand A (rs1/PC).
- `B`, in, XLEN: operand B (rs2/imm).
- `ALU_control`, in, 5: op code (see Operation).
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer takes result.
- `result`, out, XLEN: registered result.
- `zero_flag`, out, 1: registered, `result == 0`.
- `illegal_op`, out, 1: registered; op code unassigned or not compiled in.

## Operation
- Op codes, 5'hxx:
  - 00 ADD, 01 SLT, 02 SLTU, 03 AND, 04 OR, 05 XOR.
  - 06 LUI (`B << 12`), 07 SLL, 08 SRL, 09 SUB, 0A SRA.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- Shifts use `B[$clog2(XLEN)-1:0]` only. SRA is arithmetic on signed A. SLT/SLTU give 1 or 0, zero-extended.
- FSM `IDLE -> CALC -> DONE -> IDLE`.
  - IDLE: on `in_valid`, latch A, B and op.
  - Single-cycle op, special-case div, or illegal op: go to DONE with result loaded.
  - Otherwise go to CALC with counter = XLEN.
- CALC, multiply: radix-2 shift-add on operand magnitudes, 2·XLEN-bit product.
  - Sign fix-up applied in the final cycle (MULH signed×signed, MULHSU signed×unsigned).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Special cases, resolved in IDLE with no CALC cycles:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (A = most-negative, B = -1): DIV gives A; REM gives 0.
- DONE: hold `result`, `zero_flag`, `illegal_op` stable until `out_ready`, then go to IDLE.
- Unassigned op: `result` = 0, `illegal_op` = 1, `zero_flag` = 1.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `zero_flag` 1, `illegal_op` 0, counter 0.
- Input handshake fires on a cycle with `in_valid && in_ready`, at edge N.
- Single-cycle and special-case ops: `out_valid` = 1 from cycle N+1.
- Mul/div: exactly XLEN CALC cycles; `out_valid` = 1 from cycle N+XLEN+1.
- `out_valid` stays high until the cycle with `out_ready`. `in_ready` returns the following cycle.
- Minimum issue interval is 2 cycles. `in_ready` is never high in the same cycle as `out_valid`.
- Inputs are ignored when `in_ready` = 0. A, B and op may change freely after acceptance.
- `reset` mid-CALC or mid-DONE: the next cycle is IDLE with the reset values. The in-flight op is discarded and no `out_valid` is produced.
- `out_ready` while `out_valid` = 0 has no effect.

## Configuration
- `ALU_MULDIV_EN` defined: op codes 10–17 execute as specified.
- `ALU_MULDIV_EN` undefined:
  - CALC state and `alu_muldiv_iter` are not built.
  - Op codes 10–17 are treated as unassigned (1-cycle, `result` 0, `illegal_op` 1).

## Structure
- Package `alu_pkg`:
  - `alu_op_e`, the 5-bit op enum with the codes above.
  - `alu_state_e`, the FSM state enum.
  - `is_muldiv()` helper.
  - Constant `LUI_SHIFT` = 12.
- Sub-module `alu_muldiv_iter`:
  - Owns the counter, the partial product/remainder registers and the sign fix-up.
  - Handshake is start/done, instantiated under `ALU_MULDIV_EN`.
- Top `alu_seq` owns the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset, then ADD A=32'h7FFF_FFFF B=1 -> `out_valid` at N+1, `result` 32'h8000_0000, `zero_flag` 0.
- SUB A=5 B=5, with `out_ready` held low 3 cycles -> `result` 0, `zero_flag` 1, outputs stable; `in_ready` returns 1 cycle after `out_ready`.
- MULH A=32'hFFFF_FFFE (-2) B=3 -> `out_valid` at N+33, `result` 32'hFFFF_FFFF; same inputs with MUL -> 32'hFFFF_FFFA.
- DIV A=-7 B=2 -> quotient -3 (32'hFFFF_FFFD); REM same operands -> -1; both at N+33.
- Special cases at N+1:
  - DIVU A=9 B=0 -> 32'hFFFF_FFFF.
  - REM A=9 B=0 -> 9.
  - DIV A=32'h8000_0000 B=-1 -> 32'h8000_0000.
- Reset asserted at CALC cycle 10 of DIVU -> IDLE next cycle, no `out_valid`. Op 5'h1F -> `illegal_op` 1, `result` 0. Without `ALU_MULDIV_EN`, MUL -> `illegal_op` 1 at N+1.
